bit_array_bank: RTL and testbench

BIT_ARRAY_BANK -- requirements
Module: bit_array_bank

---
 rtl/bit_array_pkg.sv | 15 +
 rtl/bit_array_clr_seq.sv | 79 +++++++
 rtl/bit_array_bank.sv | 92 +++++++++
 tb/tb_bit_array_bank.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_array_pkg.sv
// Shared types and width helpers for the banked bit-addressable array.
package bit_array_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StDone
    } clr_state_e;

    // Index width that never collapses to zero bits for single-entry dimensions.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_array_clr_seq.sv
// Sequential clear walker: visits every word bank-major, one per cycle, then pulses done.
module bit_array_clr_seq
    import bit_array_pkg::*;
#(
    parameter int unsigned BANKS = 2,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned BW = clog2_min1(BANKS),
    localparam int unsigned IW = clog2_min1(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    output logic          clr_en_o,
    output logic [BW-1:0] clr_bank_o,
    output logic [IW-1:0] clr_idx_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [BW-1:0] LastBank = BW'(BANKS - 1);
    localparam logic [IW-1:0] LastIdx  = IW'(DEPTH - 1);

    clr_state_e    state_q;
    logic [BW-1:0] bank_q;
    logic [IW-1:0] idx_q;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bank_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StClear;
                        busy_q  <= 1'b1;
                        bank_q  <= '0;
                        idx_q   <= '0;
                    end
                end
                StClear: begin
                    if (idx_q == LastIdx) begin
                        idx_q <= '0;
                        if (bank_q == LastBank) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            bank_q <= bank_q + 1'b1;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en_o   = busy_q;
    assign clr_bank_o = bank_q;
    assign clr_idx_o  = idx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: rtl/bit_array_bank.sv
// Banked word array with single-bit writes, one-cycle word reads and a sequential clear.
module bit_array_bank
    import bit_array_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BANKS = 2,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned BW = clog2_min1(BANKS),
    localparam int unsigned IW = clog2_min1(DEPTH),
    localparam int unsigned SW = clog2_min1(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [BW-1:0]    wr_bank_i,
    input  logic [IW-1:0]    wr_idx_i,
    input  logic [SW-1:0]    wr_bit_i,
    input  logic             wr_val_i,
    input  logic             rd_en_i,
    input  logic [BW-1:0]    rd_bank_i,
    input  logic [IW-1:0]    rd_idx_i,
    input  logic             rd_invert_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             clr_start_i,
    output logic             clr_busy_o,
    output logic             clr_done_o
);

    logic [WIDTH-1:0] mem_q [BANKS][DEPTH];
    logic [WIDTH-1:0] mem_d [BANKS][DEPTH];
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic          clr_en;
    logic [BW-1:0] clr_bank;
    logic [IW-1:0] clr_idx;
    logic          wr_ok, rd_ok;

    bit_array_clr_seq #(
        .BANKS(BANKS),
        .DEPTH(DEPTH)
    ) u_clr_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (clr_start_i),
        .clr_en_o  (clr_en),
        .clr_bank_o(clr_bank),
        .clr_idx_o (clr_idx),
        .busy_o    (clr_busy_o),
        .done_o    (clr_done_o)
    );

    // Writes are locked out for the whole CLEAR and DONE window.
    assign wr_ok = wr_en_i && !clr_busy_o && !clr_done_o
                   && (32'(wr_bank_i) < BANKS) && (32'(wr_idx_i) < DEPTH)
                   && (32'(wr_bit_i) < WIDTH);
    assign rd_ok = (32'(rd_bank_i) < BANKS) && (32'(rd_idx_i) < DEPTH);

    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_bank][clr_idx] = '0;
        end else if (wr_ok) begin
            mem_d[wr_bank_i][wr_idx_i][wr_bit_i] = wr_val_i;
        end
    end

    // Reads sample mem_q, so a same-cycle write is not visible yet.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = rd_ok ? (mem_q[rd_bank_i][rd_idx_i] ^ {WIDTH{rd_invert_i}}) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '{default: '0};
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_valid_q <= rd_en_i;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_bit_array_bank.sv
// Scoreboard bench: a default-size instance and a DEPTH=3 instance share clock and reset.
module tb_bit_array_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       wr_en0 = 0, wr_val0 = 0, rd_en0 = 0, rd_inv0 = 0, clr_start0 = 0;
    logic [0:0] wr_bank0 = 0, wr_idx0 = 0, rd_bank0 = 0, rd_idx0 = 0;
    logic [2:0] wr_bit0 = 0;
    logic       rd_valid0, clr_busy0, clr_done0;
    logic [7:0] rd_data0;

    logic       wr_en1 = 0, wr_val1 = 0, rd_en1 = 0, rd_inv1 = 0, clr_start1 = 0;
    logic [0:0] wr_bank1 = 0, rd_bank1 = 0;
    logic [1:0] wr_idx1 = 0, rd_idx1 = 0;
    logic [2:0] wr_bit1 = 0;
    logic       rd_valid1, clr_busy1, clr_done1;
    logic [7:0] rd_data1;

    bit_array_bank u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .wr_en_i(wr_en0), .wr_bank_i(wr_bank0), .wr_idx_i(wr_idx0), .wr_bit_i(wr_bit0),
        .wr_val_i(wr_val0), .rd_en_i(rd_en0), .rd_bank_i(rd_bank0), .rd_idx_i(rd_idx0),
        .rd_invert_i(rd_inv0), .rd_valid_o(rd_valid0), .rd_data_o(rd_data0),
        .clr_start_i(clr_start0), .clr_busy_o(clr_busy0), .clr_done_o(clr_done0)
    );

    bit_array_bank #(.WIDTH(8), .BANKS(2), .DEPTH(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en_i(wr_en1), .wr_bank_i(wr_bank1), .wr_idx_i(wr_idx1), .wr_bit_i(wr_bit1),
        .wr_val_i(wr_val1), .rd_en_i(rd_en1), .rd_bank_i(rd_bank1), .rd_idx_i(rd_idx1),
        .rd_invert_i(rd_inv1), .rd_valid_o(rd_valid1), .rd_data_o(rd_data1),
        .clr_start_i(clr_start1), .clr_busy_o(clr_busy1), .clr_done_o(clr_done1)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every valid read result must match the oldest expectation.
    always @(negedge clk) begin
        if (rd_valid0 === 1'b1) begin
            if (exp_q0.size() == 0) chk("rd0_unexpected", 1, 0);
            else chk("rd0_data", {24'd0, rd_data0}, {24'd0, exp_q0.pop_front()});
        end
        if (rd_valid1 === 1'b1) begin
            if (exp_q1.size() == 0) chk("rd1_unexpected", 1, 0);
            else chk("rd1_data", {24'd0, rd_data1}, {24'd0, exp_q1.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en0 = 0; rd_en0 = 0; clr_start0 = 0;
        wr_en1 = 0; rd_en1 = 0; clr_start1 = 0;
    endtask

    task automatic drive_wr(input int d, input int b, input int i, input int bt, input int v);
        if (d == 0) begin
            wr_en0 = 1; wr_bank0 = 1'(b); wr_idx0 = 1'(i); wr_bit0 = 3'(bt); wr_val0 = 1'(v);
        end else begin
            wr_en1 = 1; wr_bank1 = 1'(b); wr_idx1 = 2'(i); wr_bit1 = 3'(bt); wr_val1 = 1'(v);
        end
    endtask

    task automatic drive_rd(input int d, input int b, input int i, input int inv,
                            input logic [7:0] exp);
        if (d == 0) begin
            rd_en0 = 1; rd_bank0 = 1'(b); rd_idx0 = 1'(i); rd_inv0 = 1'(inv);
            exp_q0.push_back(exp);
        end else begin
            rd_en1 = 1; rd_bank1 = 2'(b); rd_idx1 = 2'(i); rd_inv1 = 1'(inv);
            exp_q1.push_back(exp);
        end
    endtask

    task automatic write_word(input int d, input int b, input int i, input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            drive_wr(d, b, i, k, int'(w[k]));
            tick();
        end
    endtask

    int nb, nd;
    bit seen;

    initial begin
        #1;
        chk("rst_rd_valid", rd_valid0, 0);
        chk("rst_rd_data", rd_data0, 0);
        chk("rst_clr_busy", clr_busy0, 0);
        chk("rst_clr_done", clr_done0, 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // LSB-first 0xAD into [0][0], then plain and inverted reads.
        write_word(0, 0, 0, 8'hAD);
        drive_rd(0, 0, 0, 0, 8'hAD); tick();
        drive_rd(0, 0, 0, 1, 8'h52); tick();

        write_word(0, 1, 1, 8'h42);
        drive_rd(0, 1, 1, 0, 8'h42); tick();
        drive_rd(0, 0, 1, 0, 8'h00); tick();

        // Fill, then clear while poking clr_start, a write and reads mid-sequence.
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 2; i++) write_word(0, b, i, 8'hFF);
        clr_start0 = 1; tick();
        nb = 0; nd = 0;
        for (int k = 0; k < 12; k++) begin
            nb += int'(clr_busy0);
            nd += int'(clr_done0);
            if (k == 1) begin
                drive_rd(0, 0, 0, 0, 8'h00);
                drive_wr(0, 0, 0, 0, 1);
                clr_start0 = 1;
            end
            if (k == 2) drive_rd(0, 1, 1, 0, 8'hFF);
            if (k == 4) clr_start0 = 1;
            tick();
        end
        chk("clr_busy_cycles", nb, 4);
        chk("clr_done_pulses", nd, 1);
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 2; i++) begin
                drive_rd(0, b, i, 0, 8'h00); tick();
            end

        // Same-cycle write and read returns the pre-write word.
        drive_wr(0, 0, 0, 0, 1);
        drive_rd(0, 0, 0, 0, 8'h00); tick();
        drive_rd(0, 0, 0, 0, 8'h01); tick();

        // DEPTH=3: idx 3 is out of range for both writes and reads.
        drive_wr(1, 0, 3, 0, 1); tick();
        drive_rd(1, 0, 3, 1, 8'h00); tick();
        drive_rd(1, 0, 3, 0, 8'h00); tick();
        drive_rd(1, 0, 2, 1, 8'hFF); tick();
        drive_wr(1, 1, 2, 5, 1); tick();
        drive_rd(1, 1, 2, 0, 8'h20); tick();

        // Write and clr_start together: write lands, then the clear wipes it.
        drive_wr(1, 0, 1, 0, 1);
        clr_start1 = 1; tick();
        drive_rd(1, 0, 1, 0, 8'h01); tick();
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (clr_done1) seen = 1;
            tick();
        end
        chk("dut1_clr_done_seen", seen, 1);
        drive_rd(1, 0, 1, 0, 8'h00); tick();
        drive_rd(1, 1, 2, 0, 8'h00); tick();

        // Reset in the middle of a clear.
        drive_wr(0, 1, 1, 7, 1); tick();
        drive_rd(0, 0, 0, 1, 8'hFE); tick();
        tick();
        clr_start0 = 1; tick();
        tick(); tick();
        chk("pre_rst_busy", clr_busy0, 1);
        rst_n = 0;
        #1;
        chk("midclr_rst_busy", clr_busy0, 0);
        chk("midclr_rst_done", clr_done0, 0);
        chk("midclr_rst_valid", rd_valid0, 0);
        chk("midclr_rst_data", rd_data0, 0);
        @(posedge clk);
        #2;
        rst_n = 1;
        nb = 0; nd = 0;
        for (int k = 0; k < 6; k++) begin
            nb += int'(clr_busy0);
            nd += int'(clr_done0);
            tick();
        end
        chk("post_rst_idle_busy", nb, 0);
        chk("post_rst_no_done", nd, 0);
        drive_rd(0, 1, 1, 0, 8'h00); tick();

        clr_start0 = 1; tick();
        nb = 0; nd = 0;
        for (int k = 0; k < 10; k++) begin
            nb += int'(clr_busy0);
            nd += int'(clr_done0);
            tick();
        end
        chk("reclr_busy_cycles", nb, 4);
        chk("reclr_done_pulses", nd, 1);

        tick(); tick();
        chk("dut0_reads_drained", exp_q0.size(), 0);
        chk("dut1_reads_drained", exp_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
